// File: rtl/sng_pkg.sv
// ============================================================================
// sng_pkg : shared constants, state/mode encodings and seed helper for the
//           stochastic number generator bank.  Rev 1.0
// ============================================================================
`default_nettype none

package sng_pkg;

  // Feedback taps of the 32-bit Fibonacci LFSR
  localparam int unsigned TAP_A = 31;
  localparam int unsigned TAP_B = 21;
  localparam int unsigned TAP_C = 1;
  localparam int unsigned TAP_D = 0;

  localparam logic [31:0] SEED_STRIDE   = 32'h9E3779B9;
  localparam logic [31:0] ZERO_SEED_SUB = 32'h1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic IND  = 1'b0;
  localparam logic CORR = 1'b1;

  // An all-zero LFSR would lock up, so a zero seed is substituted
  function automatic logic [31:0] chan_seed(input logic [31:0] base, input int unsigned ch);
    logic [31:0] s;
    s = base ^ (32'(ch) * SEED_STRIDE);
    return (s == 32'h0) ? ZERO_SEED_SUB : s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sng_if.sv
// ============================================================================
// sng_if : load and stream handshake bundle of the stochastic number
//          generator bank.  Rev 1.0
// ============================================================================
`default_nettype none

interface sng_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);
  logic                         load_valid;
  logic                         load_ready;
  logic [CHANNELS*WIDTH-1:0]    load_prob;
  logic                         load_corr;
  logic                         abort;
  logic                         out_valid;
  logic                         out_ready;
  logic [CHANNELS-1:0]          out_bits;
  logic                         out_last;

  modport master (
    output load_valid, load_prob, load_corr, abort, out_ready,
    input  load_ready, out_valid, out_bits, out_last
  );

  modport slave (
    input  load_valid, load_prob, load_corr, abort, out_ready,
    output load_ready, out_valid, out_bits, out_last
  );
endinterface

`default_nettype wire

// File: rtl/sng_lfsr32.sv
// ============================================================================
// sng_lfsr32 : 32-bit Fibonacci LFSR (shift left) with seed load and step
//              enable.  Rev 1.0
// ============================================================================
`default_nettype none

module sng_lfsr32
  import sng_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic [31:0] seed,
  input  wire logic        load,
  input  wire logic        step,
  output logic      [31:0] state
);

  logic [31:0] r_state;
  logic        w_fb;

  assign w_fb  = r_state[TAP_A] ^ r_state[TAP_B] ^ r_state[TAP_C] ^ r_state[TAP_D];
  assign state = r_state;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      r_state <= seed;
    end else if (step) begin
      r_state <= {r_state[30:0], w_fb};
    end
  end

endmodule

`default_nettype wire

// File: rtl/sng_bank.sv
// ============================================================================
// sng_bank : multi-channel stochastic number generator, one frame of
//            STREAM_LEN bits per channel per load.  Rev 1.0
// ============================================================================
`default_nettype none

module sng_bank
  import sng_pkg::*;
#(
  parameter int          CHANNELS   = 4,
  parameter int          WIDTH      = 8,
  parameter int          STREAM_LEN = 256,
  parameter logic [31:0] SEED       = 32'h12345678
) (
  input  wire logic clk,
  input  wire logic rst,
  sng_if.slave      bus
);

  localparam int                CNT_W  = $clog2(STREAM_LEN);
  localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(STREAM_LEN - 1);

  state_t                    r_state;
  state_t                    w_next;
  logic                      w_accept;
  logic                      w_step;
  logic                      w_last;
  logic [CNT_W-1:0]          r_cnt;
  logic [CHANNELS*WIDTH-1:0] r_prob;
  logic                      r_corr;
  logic [CHANNELS-1:0]       w_bits;
  logic [31:0]               w_lfsr [CHANNELS];

  assign w_last       = (r_state == RUN) && (r_cnt == C_LAST);
  assign bus.out_last = w_last;
  assign bus.out_bits = w_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Abort wins over a simultaneous transfer, so the LFSRs never step on it
  always_comb begin
    w_next         = r_state;
    w_accept       = 1'b0;
    w_step         = 1'b0;
    bus.load_ready = 1'b0;
    bus.out_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        bus.load_ready = 1'b1;
        if (bus.load_valid) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        bus.out_valid = 1'b1;
        if (bus.abort) begin
          w_next = IDLE;
        end else if (bus.out_ready) begin
          w_step = 1'b1;
          if (w_last) begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_prob <= '0;
      r_corr <= IND;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_prob <= bus.load_prob;
      r_corr <= bus.load_corr;
    end else if (w_step && !w_last) begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [31:0] w_src;

    sng_lfsr32 u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .seed  (chan_seed(SEED, c)),
      .load  (w_accept),
      .step  (w_step),
      .state (w_lfsr[c])
    );

    assign w_src     = (r_corr == CORR) ? w_lfsr[0] : w_lfsr[c];
    assign w_bits[c] = (w_src[WIDTH-1:0] < r_prob[c*WIDTH +: WIDTH]);
  end

endmodule

`default_nettype wire

// File: tb/tb_sng_bank.sv
// ============================================================================
// tb_sng_bank : self-checking bench for sng_bank against a frame-level
//               reference model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_sng_bank;

  localparam int          CH      = 4;
  localparam int          W       = 8;
  localparam int          LEN     = 256;
  localparam logic [31:0] BASE    = 32'h12345678;
  localparam int          CYC_MAX = 4000;
  localparam int          NV      = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sng_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  sng_bank #(
    .CHANNELS   (CH),
    .WIDTH      (W),
    .STREAM_LEN (LEN),
    .SEED       (BASE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [CH-1:0] cap_bits   [LEN];
  logic          cap_last   [LEN];
  int            cap_n;
  logic [CH-1:0] exp_bits   [LEN];
  logic [CH-1:0] saved_bits [LEN];

  typedef struct {
    logic [31:0] probs;
    logic        corr;
    bit          rnd;
    bit          same_prev;
    int          rate [CH];   // permille, -1 = no band check
  } vec_t;

  vec_t tv [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: polynomial x^32+x^22+x^2+x+1 stepped as a bit stream
  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return (l << 1) | 32'(^(l & 32'h8020_0003));
  endfunction

  task automatic model_frame(input logic [31:0] probs, input logic corr);
    logic [31:0] l [CH];
    logic [31:0] src;
    logic [7:0]  p;
    for (int c = 0; c < CH; c++) begin
      l[c] = BASE ^ (32'(c) * 32'h9E3779B9);
      if (l[c] == 32'h0) l[c] = 32'h1;
    end
    for (int k = 0; k < LEN; k++) begin
      for (int c = 0; c < CH; c++) begin
        src = corr ? l[0] : l[c];
        p   = probs[c*W +: W];
        exp_bits[k][c] = (src[7:0] < p);
      end
      for (int c = 0; c < CH; c++) l[c] = lfsr_next(l[c]);
    end
  endtask

  task automatic do_load(input logic [31:0] probs, input logic corr);
    @(negedge clk);
    check("load_ready_idle", bus.load_ready, 1);
    bus.load_prob  = probs;
    bus.load_corr  = corr;
    bus.load_valid = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    check("valid_after_load", bus.out_valid, 1);
    check("ready_low_in_run", bus.load_ready, 0);
  endtask

  // Starts at a negedge inside RUN; stops after stop_at transfers or frame end
  task automatic collect(input bit rnd, input int stop_at, output int serr, output int cyc);
    bit            stalled;
    logic [CH-1:0] pb;
    logic          pl;
    bit            r;
    cap_n   = 0;
    serr    = 0;
    cyc     = 0;
    stalled = 0;
    pb      = '0;
    pl      = 1'b0;
    while (bus.out_valid && cap_n < stop_at && cyc < CYC_MAX) begin
      if (stalled && (bus.out_bits !== pb || bus.out_last !== pl)) serr++;
      if (bus.load_ready) serr++;
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = r;
      if (r) begin
        cap_bits[cap_n] = bus.out_bits;
        cap_last[cap_n] = bus.out_last;
        cap_n++;
      end
      stalled = !r;
      pb      = bus.out_bits;
      pl      = bus.out_last;
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
    check("frame_in_budget", 64'(cyc < CYC_MAX), 1);
  endtask

  task automatic compare_frame(input string tag, input logic [31:0] probs, input logic corr, input int n);
    int mism, lasterr, ones_a, ones_e;
    model_frame(probs, corr);
    check({tag, "_beats"}, cap_n, n);
    mism    = 0;
    lasterr = 0;
    for (int k = 0; k < cap_n && k < LEN; k++) begin
      if (cap_bits[k] !== exp_bits[k]) mism++;
      if (cap_last[k] !== (k == LEN - 1)) lasterr++;
    end
    check({tag, "_bit_mismatches"}, mism, 0);
    check({tag, "_last_errors"}, lasterr, 0);
    for (int c = 0; c < CH; c++) begin
      ones_a = 0;
      ones_e = 0;
      for (int k = 0; k < cap_n && k < LEN; k++) begin
        ones_a += int'(cap_bits[k][c]);
        ones_e += int'(exp_bits[k][c]);
      end
      check($sformatf("%s_ones_ch%0d", tag, c), ones_a, ones_e);
    end
  endtask

  initial begin
    int serr, cyc, ones, diff, viol, mism;
    logic [31:0] rp;
    logic        rc;

    tv[0] = '{32'h0000_0000,                 1'b0, 1'b0, 1'b0, '{0, 0, 0, 0}};
    tv[1] = '{{8'd255, 8'd128, 8'd64, 8'd0}, 1'b0, 1'b0, 1'b0, '{0, -1, -1, 996}};
    tv[2] = '{{8'd255, 8'd128, 8'd64, 8'd0}, 1'b0, 1'b1, 1'b1, '{0, -1, -1, 996}};
    tv[3] = '{{8'd200, 8'd64, 8'd128, 8'd128}, 1'b1, 1'b0, 1'b0, '{-1, -1, -1, -1}};
    tv[4] = '{{8'd200, 8'd64, 8'd128, 8'd128}, 1'b1, 1'b1, 1'b1, '{-1, -1, -1, -1}};

    bus.load_valid = 1'b0;
    bus.load_prob  = '0;
    bus.load_corr  = 1'b0;
    bus.abort      = 1'b0;
    bus.out_ready  = 1'b0;
    rst            = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_load_ready", bus.load_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_bits", bus.out_bits, 0);
    check("rst_out_last", bus.out_last, 0);
    rst = 1'b0;

    // Table-driven frames
    for (int i = 0; i < NV; i++) begin
      do_load(tv[i].probs, tv[i].corr);
      collect(tv[i].rnd, LEN + 1, serr, cyc);
      check($sformatf("v%0d_stall_hold", i), serr, 0);
      if (!tv[i].rnd) check($sformatf("v%0d_frame_cycles", i), cyc, LEN);
      compare_frame($sformatf("v%0d", i), tv[i].probs, tv[i].corr, LEN);
      for (int c = 0; c < CH; c++) begin
        if (tv[i].rate[c] >= 0) begin
          ones = 0;
          for (int k = 0; k < cap_n && k < LEN; k++) ones += int'(cap_bits[k][c]);
          diff = ones * 1000 / LEN - tv[i].rate[c];
          if (diff < 0) diff = -diff;
          check($sformatf("v%0d_rate_band_ch%0d", i, c), 64'(diff <= 40), 1);
        end
      end
      if (tv[i].corr) begin
        viol = 0;
        for (int k = 0; k < cap_n && k < LEN; k++) begin
          if (cap_bits[k][0] !== cap_bits[k][1]) viol++;
          if (cap_bits[k][2] && !cap_bits[k][0]) viol++;
          if (cap_bits[k][0] && !cap_bits[k][3]) viol++;
        end
        check($sformatf("v%0d_corr_relations", i), viol, 0);
      end
      if (tv[i].same_prev) begin
        mism = 0;
        for (int k = 0; k < cap_n && k < LEN; k++)
          if (cap_bits[k] !== saved_bits[k]) mism++;
        check($sformatf("v%0d_repeat_frame", i), mism, 0);
      end
      for (int k = 0; k < LEN; k++) saved_bits[k] = cap_bits[k];
    end

    // Abort after 10 beats, overriding a simultaneous transfer
    do_load(tv[1].probs, 1'b0);
    collect(1'b0, 10, serr, cyc);
    check("abort_pre_beats", cap_n, 10);
    bus.abort     = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_load_ready", bus.load_ready, 1);
    check("abort_out_last", bus.out_last, 0);
    do_load(tv[1].probs, 1'b0);
    collect(1'b0, LEN + 1, serr, cyc);
    compare_frame("after_abort", tv[1].probs, 1'b0, LEN);

    // Reset mid-frame at beat 100
    do_load(tv[3].probs, 1'b1);
    collect(1'b0, 100, serr, cyc);
    check("rst_pre_beats", cap_n, 100);
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("midrst_load_ready", bus.load_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_bits", bus.out_bits, 0);
    check("midrst_out_last", bus.out_last, 0);
    rst = 1'b0;

    // Randomized loads with random backpressure
    for (int i = 0; i < 3; i++) begin
      rp = $urandom;
      rc = 1'($urandom_range(0, 1));
      do_load(rp, rc);
      collect(1'b1, LEN + 1, serr, cyc);
      check($sformatf("rnd%0d_stall_hold", i), serr, 0);
      compare_frame($sformatf("rnd%0d", i), rp, rc, LEN);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
